// File: rtl/vga_char_overlay.sv
// -----------------------------------------------------------------------------
// vga_char_overlay
//
// Purpose:
//   Draws a W x H monochrome bitmap at (X0, Y0) on top of a VGA timing stream.
//   The bitmap row for each line comes from an external synchronous ROM. The
//   ROM holds one row per address and has a 1-cycle read latency. RGB is
//   registered two cycles after X/DE. HS/VS/DE go through an identical
//   two-stage delay so the sync outputs stay aligned with the colour outputs.
//
// Optional feature macro:
//   OVERLAY_SCALE2_EN - when defined, the bitmap is drawn 2x in both axes.
//                       The window becomes 2W x 2H, ROM_ADDR = (Y-Y0)>>1, and
//                       each bitmap bit spans two pixels. When undefined, the
//                       bitmap is drawn at 1:1 scale.
//
// Ports:
//   CLK_25     in   pixel clock
//   RST        in   asynchronous active-high reset
//   X, Y       in   active pixel column / active line (11 bits)
//   DE         in   display enable, high during active pixels
//   HS_IN      in   horizontal sync, active low
//   VS_IN      in   vertical sync, active low
//   ROM_RD     out  one-cycle read strobe (asserted while the DE-rise pixel is present)
//   ROM_ADDR   out  glyph row address (0 when not reading)
//   ROM_DATA   in   row data, valid the cycle after ROM_RD, MSB = leftmost pixel
//   VGA_R/G/B  out  8-bit colour outputs
//   VGA_HS/VS  out  sync outputs, delayed 2 cycles
//   VGA_BLANK  out  DE delayed 2 cycles
// -----------------------------------------------------------------------------
module vga_char_overlay #(
  parameter int          X0 = 144,
  parameter int          Y0 = 160,
  parameter int          W  = 272,
  parameter int          H  = 32,
  parameter int          AW = 5,
  parameter logic [23:0] FG = 24'hFF0000,
  parameter logic [23:0] BG = 24'h000000
) (
  input  logic          CLK_25,
  input  logic          RST,
  input  logic [10:0]   X,
  input  logic [10:0]   Y,
  input  logic          DE,
  input  logic          HS_IN,
  input  logic          VS_IN,
  output logic          ROM_RD,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [W-1:0]  ROM_DATA,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK
);

`ifdef OVERLAY_SCALE2_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  localparam int NPIX = W * SCALE;   // window width in pixels
  localparam int HWIN = H * SCALE;   // window height in lines
  localparam int CW   = $clog2(NPIX) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          de_prev_q;
  logic [W-1:0]  line_q, line_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;

  logic          de_rise;
  logic          in_win_y;
  logic          fetch;
  logic          pix_on;
  logic          pix_bit;

  // Output pipeline: stage 1 holds the pixel decision, stage 2 holds the colour.
  logic          on1_q, bit1_q, de1_q, hs1_q, vs1_q;
  logic [23:0]   rgb_q;
  logic          hs_q, vs_q, blank_q;

  assign de_rise  = DE & ~de_prev_q;
  assign in_win_y = (32'(Y) >= Y0) && (32'(Y) < Y0 + HWIN);

  // The fetch is issued combinationally on the DE-rise pixel (X=0). The ROM
  // captures the address on that same edge, so the row is available one cycle
  // later. This is why X0 >= 2 leaves time to latch it before the window starts.
  assign fetch    = (state_q == S_IDLE) && de_rise && in_win_y;
  assign ROM_RD   = fetch & ~RST;
  assign ROM_ADDR = ROM_RD ? AW'((Y - 11'(Y0)) >> (SCALE - 1)) : '0;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    shift_d = shift_q;
    count_d = count_q;
    phase_d = phase_q;
    pix_on  = 1'b0;
    pix_bit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch) state_d = S_WAIT;
      end
      S_WAIT: begin
        line_d  = ROM_DATA;
        state_d = S_READY;
      end
      S_READY: begin
        if (DE && (X == 11'(X0))) begin
          // The first window pixel is shown straight from line_q. The shifter
          // is then pre-advanced (1:1) or held for a second copy (2x).
          pix_on  = 1'b1;
          pix_bit = line_q[W-1];
          shift_d = (SCALE == 2) ? line_q : (line_q << 1);
          phase_d = (SCALE == 2);
          count_d = CW'(1);
          state_d = (NPIX > 1) ? S_SHIFT : S_IDLE;
        end else if (!DE) begin
          // The line ended before the window was reached.
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!DE) begin
          // DE fell mid-window: the rest of the row is clipped and never wraps.
          state_d = S_IDLE;
        end else begin
          pix_on  = 1'b1;
          pix_bit = shift_q[W-1];
          if ((SCALE == 1) || phase_q) shift_d = shift_q << 1;
          phase_d = ~phase_q;
          count_d = count_q + CW'(1);
          if (count_q == CW'(NPIX - 1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_25 or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      // Start as if DE were already high, so that releasing reset mid-line
      // does not look like a DE rise. Rendering resumes at the next real rise.
      de_prev_q <= 1'b1;
      line_q    <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      de_prev_q <= DE;
      line_q    <= line_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
    end
  end

  always_ff @(posedge CLK_25 or posedge RST) begin
    if (RST) begin
      on1_q   <= 1'b0;
      bit1_q  <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      rgb_q   <= 24'h000000;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      on1_q   <= pix_on;
      bit1_q  <= pix_bit;
      de1_q   <= DE;
      hs1_q   <= HS_IN;
      vs1_q   <= VS_IN;
      rgb_q   <= on1_q ? (bit1_q ? FG : BG) : 24'h000000;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      blank_q <= de1_q;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign VGA_BLANK = blank_q;

endmodule

// File: tb/tb_vga_char_overlay.sv
module tb_vga_char_overlay;

  logic         clk;
  logic         rst;
  logic [10:0]  x, y;
  logic         de, hs_in, vs_in;

  logic         a_rd, b_rd;
  logic [4:0]   a_addr, b_addr;
  logic [271:0] a_data, b_data;
  logic [7:0]   a_r, a_g, a_b, b_r, b_g, b_b;
  logic         a_hs, a_vs, a_blank, b_hs, b_vs, b_blank;

  logic [271:0] rom [0:31];

  logic [23:0]  a_rgb_log [0:799];
  logic [23:0]  b_rgb_log [0:799];
  logic         a_rd_log  [0:799];
  logic         b_rd_log  [0:799];
  logic [4:0]   a_addr_log [0:799];
  logic [4:0]   b_addr_log [0:799];
  logic         hs_log    [0:799];
  logic         vs_log    [0:799];
  logic         blank_log [0:799];

  int vectors;
  int miscompares;

  vga_char_overlay u_a (
    .CLK_25(clk), .RST(rst), .X(x), .Y(y), .DE(de), .HS_IN(hs_in), .VS_IN(vs_in),
    .ROM_RD(a_rd), .ROM_ADDR(a_addr), .ROM_DATA(a_data),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK(a_blank)
  );

  vga_char_overlay #(.X0(600)) u_b (
    .CLK_25(clk), .RST(rst), .X(x), .Y(y), .DE(de), .HS_IN(hs_in), .VS_IN(vs_in),
    .ROM_RD(b_rd), .ROM_ADDR(b_addr), .ROM_DATA(b_data),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK(b_blank)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Synchronous bitmap ROMs, 1-cycle read latency.
  always @(posedge clk) begin
    if (a_rd) a_data <= rom[a_addr];
    if (b_rd) b_data <= rom[b_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pixel colour from the bitmap window definition.
  function automatic logic [23:0] exp_pix(input int x0, input int yy, input int xx);
    logic [271:0] row;
    if (yy < 160 || yy >= 192) return 24'h000000;
    if (xx < x0 || xx >= x0 + 272 || xx >= 640) return 24'h000000;
    row = rom[yy - 160];
    return row[271 - (xx - x0)] ? 24'hFF0000 : 24'h000000;
  endfunction

  // One 800-cycle line: 640 active, HS low for cycles 656..751.
  task automatic run_line(input int yy, input bit vs_low);
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      x     = (c < 640) ? 11'(c) : 11'd0;
      y     = 11'(yy);
      de    = (c < 640);
      hs_in = !(c >= 656 && c < 752);
      vs_in = !vs_low;
      @(negedge clk);
      a_rgb_log[c]  = {a_r, a_g, a_b};
      b_rgb_log[c]  = {b_r, b_g, b_b};
      a_rd_log[c]   = a_rd;
      b_rd_log[c]   = b_rd;
      a_addr_log[c] = a_addr;
      b_addr_log[c] = b_addr;
      hs_log[c]     = a_hs;
      vs_log[c]     = a_vs;
      blank_log[c]  = a_blank;
    end
  endtask

  task automatic check_line(input int yy);
    int  a_cnt, b_cnt;
    bit  exp_fetch;
    exp_fetch = (yy >= 160 && yy < 192);
    a_cnt = 0;
    b_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      if (a_rd_log[c]) a_cnt++;
      if (b_rd_log[c]) b_cnt++;
    end
    chk($sformatf("A_rdcnt_y%0d", yy), 32'(a_cnt), exp_fetch ? 32'd1 : 32'd0);
    chk($sformatf("B_rdcnt_y%0d", yy), 32'(b_cnt), exp_fetch ? 32'd1 : 32'd0);
    if (exp_fetch) begin
      chk($sformatf("A_rd_x0_y%0d", yy), 32'(a_rd_log[0]), 32'd1);
      chk($sformatf("A_addr_y%0d", yy), 32'(a_addr_log[0]), 32'(yy - 160));
      chk($sformatf("B_addr_y%0d", yy), 32'(b_addr_log[0]), 32'(yy - 160));
    end
    // Pixel X shows up two cycles later in the log.
    for (int xx = 0; xx < 640; xx++) begin
      chk($sformatf("A_px_y%0d_x%0d", yy, xx), 32'(a_rgb_log[xx + 2]), 32'(exp_pix(144, yy, xx)));
      chk($sformatf("B_px_y%0d_x%0d", yy, xx), 32'(b_rgb_log[xx + 2]), 32'(exp_pix(600, yy, xx)));
    end
  endtask

  initial begin
    int fg_cnt, hs_low;
    vectors     = 0;
    miscompares = 0;
    for (int r = 0; r < 32; r++) rom[r] = '0;
    rom[0]  = '1;
    rom[1]  = {136{2'b10}};
    rom[3]  = {1'b1, 270'd0, 1'b1};
    rom[31] = {17{16'h00FF}};

    // Reset held 5 cycles with mid-frame inputs (DE high, syncs low).
    rst = 1'b1; x = 11'd300; y = 11'd100; de = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 x = x + 11'd1;
      @(negedge clk);
      chk("rst_rgb",   32'({a_r, a_g, a_b}), 32'h0);
      chk("rst_hs",    32'(a_hs), 32'd1);
      chk("rst_vs",    32'(a_vs), 32'd1);
      chk("rst_blank", 32'(a_blank), 32'd0);
      chk("rst_rd",    32'(a_rd), 32'd0);
      chk("rst_addr",  32'(a_addr), 32'd0);
      chk("rst_b_rgb", 32'({b_r, b_g, b_b}), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0; de = 1'b0; hs_in = 1'b1; vs_in = 1'b1; x = 11'd0; y = 11'd158;
    repeat (4) @(posedge clk);

    run_line(159, 1'b0);
    check_line(159);

    run_line(160, 1'b0);
    check_line(160);
    fg_cnt = 0;
    for (int c = 0; c < 800; c++) if (a_rgb_log[c] == 24'hFF0000) fg_cnt++;
    chk("A_fg_count_row0", 32'(fg_cnt), 32'd272);
    chk("A_x143", 32'(a_rgb_log[145]), 32'h0);
    chk("A_x144", 32'(a_rgb_log[146]), 32'hFF0000);
    chk("A_x415", 32'(a_rgb_log[417]), 32'hFF0000);
    chk("A_x416", 32'(a_rgb_log[418]), 32'h0);
    hs_low = 0;
    for (int c = 0; c < 800; c++) if (!hs_log[c]) hs_low++;
    chk("hs_width",    32'(hs_low), 32'd96);
    chk("hs_pre",      32'(hs_log[657]), 32'd1);
    chk("hs_first",    32'(hs_log[658]), 32'd0);
    chk("hs_last",     32'(hs_log[753]), 32'd0);
    chk("hs_post",     32'(hs_log[754]), 32'd1);
    chk("blank_pre",   32'(blank_log[1]), 32'd0);
    chk("blank_first", 32'(blank_log[2]), 32'd1);
    chk("blank_last",  32'(blank_log[641]), 32'd1);
    chk("blank_post",  32'(blank_log[642]), 32'd0);

    run_line(161, 1'b0);
    check_line(161);

    run_line(163, 1'b0);
    check_line(163);
    chk("A_row3_x144", 32'(a_rgb_log[146]), 32'hFF0000);
    chk("A_row3_x145", 32'(a_rgb_log[147]), 32'h0);
    chk("A_row3_x414", 32'(a_rgb_log[416]), 32'h0);
    chk("A_row3_x415", 32'(a_rgb_log[417]), 32'hFF0000);

    run_line(191, 1'b0);
    check_line(191);

    run_line(192, 1'b1);
    check_line(192);
    chk("vs_pre",   32'(vs_log[1]), 32'd1);
    chk("vs_first", 32'(vs_log[2]), 32'd0);
    chk("vs_mid",   32'(vs_log[799]), 32'd0);

    run_line(193, 1'b0);
    check_line(193);
    chk("vs_tail", 32'(vs_log[1]), 32'd0);
    chk("vs_end",  32'(vs_log[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
